sad_status_leds: RTL



---
 rtl/sad_status_leds_pkg.sv | 24 ++
 rtl/sad_status_leds_if.sv | 28 ++
 rtl/sad_led_prescaler.sv | 28 ++
 rtl/sad_status_leds.sv | 104 ++++++++++
 4 files changed

// File: rtl/sad_status_leds_pkg.sv
// rtl/sad_status_leds_pkg.sv - shared state encodings for the SAD status LED block
package sad_status_leds_pkg;

   localparam int SAD_LED_STATE_W = 3;

   typedef enum logic [SAD_LED_STATE_W-1:0] {
      SAD_LED_IDLE   = 3'd0,
      SAD_LED_ARMED  = 3'd1,
      SAD_LED_ACTIVE = 3'd2,
      SAD_LED_TRIG   = 3'd3,
      SAD_LED_ERROR  = 3'd4
   } sad_led_state_e;

   // Where the FSM settles once a trigger hold ends or matching is switched off.
   function automatic sad_led_state_e sad_led_fall_back(input logic active, input logic armed);
      if (active)
         return SAD_LED_ACTIVE;
      else if (armed)
         return SAD_LED_ARMED;
      else
         return SAD_LED_IDLE;
   endfunction

endpackage

// File: rtl/sad_status_leds_if.sv
// rtl/sad_status_leds_if.sv - SAD control flags in, front-panel LEDs and readback out
interface sad_status_leds_if
   import sad_status_leds_pkg::*;
#(
   parameter int pCNT_BITS = 8
);
   logic                       sad_reset;
   logic                       armed_and_ready;
   logic                       sad_active;
   logic                       xadc_error;
   logic                       trig_event;
   logic                       led_armed;
   logic                       led_capture;
   logic                       led_error;
   logic [SAD_LED_STATE_W-1:0] state_o;
   logic [pCNT_BITS-1:0]       trig_count;

   modport master (
      output sad_reset, armed_and_ready, sad_active, xadc_error, trig_event,
      input  led_armed, led_capture, led_error, state_o, trig_count
   );

   modport slave (
      input  sad_reset, armed_and_ready, sad_active, xadc_error, trig_event,
      output led_armed, led_capture, led_error, state_o, trig_count
   );

endinterface

// File: rtl/sad_led_prescaler.sv
// rtl/sad_led_prescaler.sv - free-running blink prescaler with 3-bit phase counter
module sad_led_prescaler #(
   parameter int pPRESC_BITS = 22
) (
   input  logic       clk_usb,
   input  logic       reset_i,
   output logic       tick,
   output logic [2:0] phase
);

   logic [pPRESC_BITS-1:0] presc;
   logic [2:0]             phase_q;

   assign tick  = &presc;
   assign phase = phase_q;

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         presc   <= '0;
         phase_q <= 3'd0;
      end else begin
         presc <= presc + pPRESC_BITS'(1);
         if (tick)
            phase_q <= phase_q + 3'd1;
      end
   end

endmodule

// File: rtl/sad_status_leds.sv
// rtl/sad_status_leds.sv - SAD trigger status FSM, saturating trigger counter and LED drivers
module sad_status_leds
   import sad_status_leds_pkg::*;
#(
   parameter int pPRESC_BITS = 22,
   parameter int pHOLD_TICKS = 4,
   parameter int pCNT_BITS   = 8
) (
   input logic                 clk_usb,
   input logic                 reset_i,
   sad_status_leds_if.slave    bus
);

   localparam int HOLD_W = $clog2(pHOLD_TICKS + 1);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(pHOLD_TICKS);

   logic                 tick;
   logic [2:0]           phase;
   sad_led_state_e       state_q;
   logic [HOLD_W-1:0]    hold_cnt;
   logic [pCNT_BITS-1:0] trig_count_q;
   logic [pCNT_BITS-1:0] trig_count_inc;
   logic                 led_armed_q;
   logic                 led_capture_q;
   logic                 led_error_q;

   sad_led_prescaler #(
      .pPRESC_BITS (pPRESC_BITS)
   ) u_prescaler (
      .clk_usb (clk_usb),
      .reset_i (reset_i),
      .tick    (tick),
      .phase   (phase)
   );

   assign trig_count_inc = (&trig_count_q) ? trig_count_q : trig_count_q + pCNT_BITS'(1);

   assign bus.state_o     = state_q;
   assign bus.trig_count  = trig_count_q;
   assign bus.led_armed   = led_armed_q;
   assign bus.led_capture = led_capture_q;
   assign bus.led_error   = led_error_q;

   always_ff @(posedge clk_usb) begin
      if (reset_i) begin
         state_q       <= SAD_LED_IDLE;
         hold_cnt      <= '0;
         trig_count_q  <= '0;
         led_armed_q   <= 1'b0;
         led_capture_q <= 1'b0;
         led_error_q   <= 1'b0;
      end else begin
         // LEDs follow the state register, so they trail state_o by one cycle.
         led_armed_q   <= (state_q == SAD_LED_ARMED) || (state_q == SAD_LED_TRIG) ||
                          ((state_q == SAD_LED_ACTIVE) && phase[2]);
         led_capture_q <= (state_q == SAD_LED_TRIG);
         led_error_q   <= (state_q == SAD_LED_ERROR) && phase[0];

         if (bus.sad_reset) begin
            state_q      <= SAD_LED_IDLE;
            trig_count_q <= '0;
            hold_cnt     <= '0;
         end else if (bus.xadc_error) begin
            state_q <= SAD_LED_ERROR;
         end else begin
            case (state_q)
               SAD_LED_IDLE: begin
                  if (bus.armed_and_ready)
                     state_q <= SAD_LED_ARMED;
               end
               SAD_LED_ARMED: begin
                  if (bus.sad_active)
                     state_q <= SAD_LED_ACTIVE;
                  else if (!bus.armed_and_ready)
                     state_q <= SAD_LED_IDLE;
               end
               SAD_LED_ACTIVE: begin
                  if (bus.trig_event) begin
                     state_q      <= SAD_LED_TRIG;
                     hold_cnt     <= HOLD_LOAD;
                     trig_count_q <= trig_count_inc;
                  end else if (!bus.sad_active) begin
                     state_q <= sad_led_fall_back(1'b0, bus.armed_and_ready);
                  end
               end
               SAD_LED_TRIG: begin
                  if (bus.trig_event) begin
                     hold_cnt     <= HOLD_LOAD;
                     trig_count_q <= trig_count_inc;
                  end else if (tick) begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                     if (hold_cnt == HOLD_W'(1))
                        state_q <= sad_led_fall_back(bus.sad_active, bus.armed_and_ready);
                  end
               end
               SAD_LED_ERROR: begin
               end
               default: state_q <= SAD_LED_IDLE;
            endcase
         end
      end
   end

endmodule
